// File: rtl/mul_result_combiner_if.sv
// Handshake and data bundle between the multiply cell / issue logic and the
// result combiner. The combiner takes the slave view; the issuing side and
// the result consumer together take the master view.
interface mul_result_combiner_if #(
  parameter int TAG_W = 5
);
  logic             M_en;
  logic             issue_valid;
  logic [TAG_W-1:0] issue_tag;
  logic             issue_ready;
  logic [31:0]      M_mul_cell_p1;
  logic [31:0]      M_mul_cell_p2;
  logic [31:0]      M_mul_cell_p3;
  logic             res_valid;
  logic [31:0]      res_data;
  logic [TAG_W-1:0] res_tag;
  logic             res_ready;

  modport slave (
    input  M_en, issue_valid, issue_tag,
    input  M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
    input  res_ready,
    output issue_ready, res_valid, res_data, res_tag
  );

  modport master (
    output M_en, issue_valid, issue_tag,
    output M_mul_cell_p1, M_mul_cell_p2, M_mul_cell_p3,
    output res_ready,
    input  issue_ready, res_valid, res_data, res_tag
  );
endinterface

// File: rtl/mul_result_combiner.sv
// Result combiner for the Nios II multiply cell: folds the three 16x16 partial
// products into the low 32-bit word of the product, carries the destination
// tag along, and queues results in a small FIFO. A credit counter limits the
// number of accepted-but-unpopped multiplies to the FIFO depth, so the two
// pipeline stages never stall and the FIFO can never overflow.
module mul_result_combiner #(
  parameter int FIFO_DEPTH = 4,
  parameter int TAG_W      = 5
) (
  input logic                  clk,
  input logic                  reset,
  mul_result_combiner_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
  } entry_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake qualifiers
  logic issue_ready;
  logic accept;
  logic pop;

  // Credit counter
  logic [CNT_W-1:0] credit_q, credit_d;

  // Pipeline: stage 0 holds the tag while the cell finishes, stage A holds
  // the partially combined product.
  logic             v0_q;
  logic [TAG_W-1:0] tag0_q;
  logic             va_q;
  logic [15:0]      mid_q;
  logic [31:0]      p1a_q;
  logic [TAG_W-1:0] taga_q;
  entry_t           wr_entry;

  // FIFO storage, pointers and the registered head
  entry_t           mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fill_q, fill_d;
  entry_t           head_d;
  logic             res_valid_q;
  entry_t           res_q;

  // Upper halves of the cross products only affect bits above 31.
  logic unused_hi;
  assign unused_hi = ^{bus.M_mul_cell_p2[31:16], bus.M_mul_cell_p3[31:16]};

  assign pop         = res_valid_q & bus.res_ready;
  assign issue_ready = ~reset & ((credit_q < DEPTH_C) | pop);
  assign accept      = bus.issue_valid & issue_ready & bus.M_en;

  assign bus.issue_ready = issue_ready;
  assign bus.res_valid   = res_valid_q;
  assign bus.res_data    = res_q.data;
  assign bus.res_tag     = res_q.tag;

  assign wr_entry = '{tag: taga_q, data: p1a_q + {mid_q, 16'h0000}};

  // Credit next-state: accept takes a credit, pop returns one.
  always_comb begin
    // NOTE: default assignment first so every path drives credit_d and no latch is inferred.
    credit_d = credit_q;
    if (accept && !pop)      credit_d = credit_q + CNT_W'(1);
    else if (pop && !accept) credit_d = credit_q - CNT_W'(1);
  end

  // Credit register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) credit_q <= '0;
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    else       credit_q <= credit_d;
  end

  // Two-stage combine pipeline; advances every cycle, never stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0_q   <= 1'b0;
      tag0_q <= '0;
      va_q   <= 1'b0;
      mid_q  <= '0;
      p1a_q  <= '0;
      taga_q <= '0;
    end else begin
      v0_q <= accept;
      va_q <= v0_q;
      if (accept) tag0_q <= bus.issue_tag;
      if (v0_q) begin
        mid_q  <= bus.M_mul_cell_p2[15:0] + bus.M_mul_cell_p3[15:0];
        p1a_q  <= bus.M_mul_cell_p1;
        taga_q <= tag0_q;
      end
    end
  end

  // FIFO next-state and the entry that will sit at the head next cycle.
  // A write into an empty FIFO becomes the head without bypassing this cycle.
  always_comb begin
    wr_ptr_d = va_q ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fill_d   = fill_q;
    if (va_q && !pop)      fill_d = fill_q + CNT_W'(1);
    else if (pop && !va_q) fill_d = fill_q - CNT_W'(1);
    head_d = (va_q && (rd_ptr_d == wr_ptr_q)) ? wr_entry : mem_q[rd_ptr_d];
  end

  // FIFO storage write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; entries are only read after being written, and the output register is reset instead.
    if (va_q) mem_q[wr_ptr_q] <= wr_entry;
  end

  // FIFO pointers and registered head; the head holds its last value once empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      res_valid_q <= 1'b0;
      res_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= fill_d;
      res_valid_q <= (fill_d != '0);
      if (fill_d != '0) res_q <= head_d;
    end
  end

  // Credit must make a full-FIFO write and counter wrap impossible.
  a_no_full_write: assert property (@(posedge clk) disable iff (reset)
    !(va_q && (fill_q == DEPTH_C)));
  a_credit_over: assert property (@(posedge clk) disable iff (reset)
    !(accept && !pop && (credit_q == DEPTH_C)));
  a_credit_under: assert property (@(posedge clk) disable iff (reset)
    !(pop && !accept && (credit_q == '0)));

endmodule

// File: tb/tb_mul_result_combiner.sv
// Directed bench for mul_result_combiner with a behavioural multiply cell
// that registers the three partial products when M_en is high.
module tb_mul_result_combiner;

  localparam int TAG_W = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [31:0] cell_p1 = '0;
  logic [31:0] cell_p2 = '0;
  logic [31:0] cell_p3 = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  mul_result_combiner_if #(.TAG_W(TAG_W)) bus ();

  mul_result_combiner #(.FIFO_DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Multiply cell model: operands captured at the end of the enabled cycle.
  always @(posedge clk) begin
    if (bus.M_en) begin
      cell_p1 <= 32'(src1[15:0])  * 32'(src2[15:0]);
      cell_p2 <= 32'(src1[15:0])  * 32'(src2[31:16]);
      cell_p3 <= 32'(src1[31:16]) * 32'(src2[15:0]);
    end
  end

  assign bus.M_mul_cell_p1 = cell_p1;
  assign bus.M_mul_cell_p2 = cell_p2;
  assign bus.M_mul_cell_p3 = cell_p3;

  function automatic logic [31:0] low_prod(input logic [31:0] a, input logic [31:0] b);
    return a * b;
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic check_tag(input string tag, input logic [TAG_W-1:0] obs, input logic [TAG_W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge (the drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [TAG_W-1:0] t, input logic [31:0] a, input logic [31:0] b);
    bus.issue_valid = 1'b1;
    bus.M_en        = 1'b1;
    bus.issue_tag   = t;
    src1            = a;
    src2            = b;
    #1;
  endtask

  task automatic idle();
    bus.issue_valid = 1'b0;
    bus.M_en        = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.issue_valid = 1'b0;
    bus.M_en        = 1'b0;
    bus.issue_tag   = '0;
    bus.res_ready   = 1'b1;

    // Reset state
    tick();
    tick();
    check_bit ("rst_res_valid",   bus.res_valid,   1'b0);
    check_bit ("rst_issue_ready", bus.issue_ready, 1'b0);
    check_word("rst_res_data",    bus.res_data,    32'h0);
    check_tag ("rst_res_tag",     bus.res_tag,     5'd0);
    reset = 1'b0;
    #1;
    check_bit("post_rst_ready", bus.issue_ready, 1'b1);

    // 1: basic product and fixed 3-cycle latency
    present(5'd3, 32'h0001_0002, 32'h0003_0004);
    check_bit("t1_ready", bus.issue_ready, 1'b1);
    tick();
    idle();
    check_bit("t1_valid_T1", bus.res_valid, 1'b0);
    tick();
    check_bit("t1_valid_T2", bus.res_valid, 1'b0);
    tick();
    check_bit ("t1_valid_T3", bus.res_valid, 1'b1);
    check_word("t1_data",     bus.res_data,  32'h000A_0008);
    check_tag ("t1_tag",      bus.res_tag,   5'd3);
    tick();
    check_bit ("t1_drained", bus.res_valid, 1'b0);
    check_word("t1_hold",    bus.res_data,  32'h000A_0008);

    // 2: all-ones operands, wrap and discarded mid carry
    present(5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    tick();
    idle();
    tick();
    tick();
    check_bit ("t2_valid", bus.res_valid, 1'b1);
    check_word("t2_data",  bus.res_data,  32'h0000_0001);
    check_tag ("t2_tag",   bus.res_tag,   5'd7);
    tick();

    // 3: credit exhaustion with res_ready low, then drain in order
    bus.res_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      present(TAG_W'(k), 32'(k + 1), 32'(k + 2));
      check_bit("t3_ready_credit", bus.issue_ready, 1'b1);
      tick();
    end
    present(5'd4, 32'd5, 32'd6);
    check_bit("t3_ready_full", bus.issue_ready, 1'b0);
    tick();
    tick();
    tick();
    check_bit("t3_ready_still_full", bus.issue_ready, 1'b0);
    check_bit("t3_fifo_valid",       bus.res_valid,   1'b1);
    check_tag("t3_head_tag0",        bus.res_tag,     5'd0);
    check_word("t3_head_data0",      bus.res_data,    low_prod(32'd1, 32'd2));
    bus.res_ready = 1'b1;
    #1;
    check_bit("t3_ready_on_pop", bus.issue_ready, 1'b1);
    tick();
    present(5'd5, 32'd6, 32'd7);
    check_bit("t3_ready_tag5", bus.issue_ready, 1'b1);
    check_tag("t3_head_tag1",  bus.res_tag,     5'd1);
    check_word("t3_head_data1", bus.res_data,   low_prod(32'd2, 32'd3));
    tick();
    idle();
    for (int k = 2; k < 6; k++) begin
      check_bit ("t3_drain_valid", bus.res_valid, 1'b1);
      check_tag ("t3_drain_tag",   bus.res_tag,   TAG_W'(k));
      check_word("t3_drain_data",  bus.res_data,  low_prod(32'(k + 1), 32'(k + 2)));
      tick();
    end
    check_bit ("t3_empty",     bus.res_valid,   1'b0);
    check_word("t3_hold_last", bus.res_data,    low_prod(32'd6, 32'd7));
    check_bit ("t3_credit_back", bus.issue_ready, 1'b1);

    // 4: pop and accept in the same cycle at full credit
    bus.res_ready = 1'b0;
    for (int k = 10; k < 14; k++) begin
      present(TAG_W'(k), 32'(k), 32'd2);
      tick();
    end
    idle();
    tick();
    tick();
    tick();
    check_bit("t4_full_not_ready", bus.issue_ready, 1'b0);
    check_tag("t4_head_tag10",     bus.res_tag,     5'd10);
    bus.res_ready = 1'b1;
    present(5'd14, 32'd14, 32'd2);
    check_bit("t4_ready_pop_full", bus.issue_ready, 1'b1);
    tick();
    bus.res_ready = 1'b0;
    present(5'd15, 32'd15, 32'd2);
    check_bit("t4_credit_stays_full", bus.issue_ready, 1'b0);
    check_tag("t4_head_tag11",        bus.res_tag,     5'd11);
    tick();
    idle();
    tick();
    tick();
    tick();
    bus.res_ready = 1'b1;
    #1;
    for (int k = 11; k < 15; k++) begin
      check_bit ("t4_drain_valid", bus.res_valid, 1'b1);
      check_tag ("t4_drain_tag",   bus.res_tag,   TAG_W'(k));
      check_word("t4_drain_data",  bus.res_data,  32'(2 * k));
      tick();
    end
    check_bit("t4_no_tag15", bus.res_valid, 1'b0);

    // 5: issue_valid with M_en low is never accepted
    bus.issue_valid = 1'b1;
    bus.M_en        = 1'b0;
    bus.issue_tag   = 5'd20;
    src1 = 32'd9;
    src2 = 32'd9;
    #1;
    tick();
    bus.issue_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check_bit("t5_no_result", bus.res_valid, 1'b0);
      tick();
    end

    // 6: reset with two results in the pipe and two in the FIFO
    bus.res_ready = 1'b0;
    for (int k = 1; k < 5; k++) begin
      present(TAG_W'(k), 32'(k), 32'd3);
      tick();
    end
    idle();
    check_bit("t6_fifo_before_rst", bus.res_valid, 1'b1);
    reset = 1'b1;
    #1;
    check_bit ("t6_rst_valid", bus.res_valid,   1'b0);
    check_bit ("t6_rst_ready", bus.issue_ready, 1'b0);
    check_word("t6_rst_data",  bus.res_data,    32'h0);
    tick();
    reset = 1'b0;
    bus.res_ready = 1'b1;
    #1;
    check_bit("t6_ready_after_rst", bus.issue_ready, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_bit("t6_no_stale", bus.res_valid, 1'b0);
    end
    present(5'd9, 32'h0002_0003, 32'h0000_0005);
    tick();
    idle();
    tick();
    tick();
    check_bit ("t6_new_valid", bus.res_valid, 1'b1);
    check_word("t6_new_data",  bus.res_data,  32'h000A_000F);
    check_tag ("t6_new_tag",   bus.res_tag,   5'd9);
    tick();
    check_bit("t6_drained", bus.res_valid, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
